// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the multiply/divide sequencer.
// Signal names follow the existing pipeline netlist so the unit drops in unchanged.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             iStart;
  logic [2:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iRead;
  logic [WIDTH-1:0] oHI;
  logic [WIDTH-1:0] oLO;
  logic             oBusy;
  logic             oStall;
  logic             oDone;
  logic             oDivZero;

  // Pipeline side: issues requests, observes HI/LO and the stall.
  modport master (
    output iStart, iOp, iA, iB, iRead,
    input  oHI, oLO, oBusy, oStall, oDone, oDivZero
  );

  // Sequencer side.
  modport slave (
    input  iStart, iOp, iA, iB, iRead,
    output oHI, oLO, oBusy, oStall, oDone, oDivZero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// MULT/MULTU use WIDTH steps of shift-add, DIV/DIVU use WIDTH steps of restoring division,
// both on unsigned magnitudes; a final FIX cycle applies signs and writes HI/LO.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic            iCLK,
  input logic            iRST,
  muldiv_sequencer_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Upper half: partial product / partial remainder. Lower half: multiplier / dividend-quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               busy;
  logic               op_arith;
  logic               op_signed;
  logic               op_div;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH:0]     div_rem;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand decode and magnitude extraction for the accept edge.
  always_comb begin
    op_arith  = (bus.iOp == OpMult) || (bus.iOp == OpMultu) ||
                (bus.iOp == OpDiv)  || (bus.iOp == OpDivu);
    op_signed = (bus.iOp == OpMult) || (bus.iOp == OpDiv);
    op_div    = (bus.iOp == OpDiv)  || (bus.iOp == OpDivu);
    a_neg     = op_signed && bus.iA[WIDTH-1];
    b_neg     = op_signed && bus.iB[WIDTH-1];
    // Negating the most negative value yields the same bit pattern, read as unsigned 2^(W-1).
    a_mag     = a_neg ? -bus.iA : bus.iA;
    b_mag     = b_neg ? -bus.iB : bus.iB;
  end

  // One iteration step of each algorithm, plus the sign fix-up of the final result.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_fits  = div_shift >= {1'b0, opnd_q};
    div_rem   = div_fits ? (div_shift - {1'b0, opnd_q}) : div_shift;
    div_next  = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_fits};
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic: accept/MT writes in IDLE, iterate in RUN, commit in FIX.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.iStart) begin
          if (op_arith) begin
            if (op_div && (bus.iB == '0)) begin
              // Divide by zero: flag it, leave HI/LO alone, never go busy.
              div_zero_d = 1'b1;
            end else begin
              state_d   = StRun;
              cnt_d     = '0;
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              opnd_d    = b_mag;
              is_div_d  = op_div;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
            end
          end else if (bus.iOp == OpMthi) begin
            hi_d = bus.iA;
          end else if (bus.iOp == OpMtlo) begin
            lo_d = bus.iA;
          end
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset that aborts any operation.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Outputs; stall holds back any HI/LO access or new issue while an operation is in flight.
  always_comb begin
    busy         = state_q != StIdle;
    bus.oHI      = hi_q;
    bus.oLO      = lo_q;
    bus.oBusy    = busy;
    bus.oStall   = (bus.iStart || bus.iRead) && busy;
    bus.oDone    = done_q;
    bus.oDivZero = div_zero_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus randomized operations checked
// against an arithmetic reference model of HI/LO.
module tb_muldiv_sequencer;

  logic iCLK;
  logic iRST;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  // Reference model: plain signed/unsigned arithmetic on the architectural values.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); ref_hi = p[63:32]; ref_lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; ref_hi = p[63:32]; ref_lo = p[31:0]; end
      3'd2: if (b != 0) begin ref_lo = 32'(sa / sb); ref_hi = 32'(sa % sb); end
      3'd3: if (b != 0) begin ref_lo = a / b; ref_hi = a % b; end
      3'd4: ref_hi = a;
      3'd5: ref_lo = a;
      default: ;
    endcase
  endtask

  // Issue one iterative op, hold iRead through the busy window and scramble the operand inputs.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_n, output int stall_n, output bit held,
                       output logic done_seen, output logic [31:0] hi, output logic [31:0] lo);
    logic [31:0] hi0, lo0;
    hi0 = bus.oHI;
    lo0 = bus.oLO;
    @(negedge iCLK);
    bus.iStart = 1'b1; bus.iOp = op; bus.iA = a; bus.iB = b;
    @(negedge iCLK);
    bus.iStart = 1'b0; bus.iRead = 1'b1; bus.iA = $urandom; bus.iB = $urandom;
    #2;
    busy_n = 0; stall_n = 0; held = 1'b1;
    while (bus.oBusy && busy_n < 100) begin
      busy_n++;
      if (bus.oStall) stall_n++;
      if (bus.oHI !== hi0 || bus.oLO !== lo0) held = 1'b0;
      @(negedge iCLK);
      bus.iA = $urandom; bus.iB = $urandom;
      #2;
    end
    bus.iRead = 1'b0;
    done_seen = bus.oDone;
    hi = bus.oHI;
    lo = bus.oLO;
  endtask

  // Single-cycle MTHI/MTLO write.
  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge iCLK);
    bus.iStart = 1'b1; bus.iOp = op; bus.iA = a;
    @(negedge iCLK);
    bus.iStart = 1'b0;
    #2;
    model_apply(op, a, 32'h0);
  endtask

  // Run one iterative op and check timing, stall, hold and result against the model.
  task automatic run_and_check(input string name, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    int busy_n, stall_n;
    bit held;
    logic done_seen;
    logic [31:0] hi, lo;
    do_op(op, a, b, busy_n, stall_n, held, done_seen, hi, lo);
    model_apply(op, a, b);
    n_total++;
    if (busy_n !== 33) $display("FAIL %s busy_cycles: got %0d want 33", name, busy_n);
    else n_pass++;
    n_total++;
    if (stall_n !== 33) $display("FAIL %s stall_cycles: got %0d want 33", name, stall_n);
    else n_pass++;
    n_total++;
    if (held !== 1'b1) $display("FAIL %s hilo_hold: got %0d want 1", name, held);
    else n_pass++;
    n_total++;
    if (done_seen !== 1'b1) $display("FAIL %s done: got %b want 1", name, done_seen);
    else n_pass++;
    n_total++;
    if (hi !== ref_hi || lo !== ref_lo)
      $display("FAIL %s result: got %h_%h want %h_%h (a=%h b=%h)",
               name, hi, lo, ref_hi, ref_lo, a, b);
    else n_pass++;
    @(negedge iCLK);
    #2;
    n_total++;
    if (bus.oDone !== 1'b0) $display("FAIL %s done_pulse_width: got %b want 0", name, bus.oDone);
    else n_pass++;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    #2;
    n_total++;
    if (bus.oHI !== 32'h0 || bus.oLO !== 32'h0)
      $display("FAIL reset_hilo: got %h_%h want 0_0", bus.oHI, bus.oLO);
    else n_pass++;
    n_total++;
    if ({bus.oBusy, bus.oDone, bus.oDivZero, bus.oStall} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000",
               {bus.oBusy, bus.oDone, bus.oDivZero, bus.oStall});
    else n_pass++;
  endtask

  task automatic test_mult();
    run_and_check("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7);
    run_and_check("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_and_check("mult_minneg", 3'd0, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 8; i++) begin
      run_and_check("mult_rand", 3'(i % 2), $urandom, $urandom);
    end
  endtask

  task automatic test_div();
    run_and_check("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run_and_check("divu_7by2", 3'd3, 32'hFFFF_FFF9, 32'd2);
    run_and_check("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_and_check("div_neg_divisor", 3'd2, 32'd100, 32'hFFFF_FFF9);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
      if (b == 0) b = 32'd1;
      if (i[0]) b = -b;
      run_and_check("div_rand", 3'(2 + (i % 2)), a, b);
    end
  endtask

  task automatic test_divzero();
    do_mt(3'd4, 32'h11);
    do_mt(3'd5, 32'h22);
    n_total++;
    if (bus.oHI !== 32'h11 || bus.oLO !== 32'h22)
      $display("FAIL mt_preset: got %h_%h want 11_22", bus.oHI, bus.oLO);
    else n_pass++;
    for (int k = 2; k <= 3; k++) begin
      @(negedge iCLK);
      bus.iStart = 1'b1; bus.iOp = 3'(k); bus.iA = $urandom; bus.iB = 32'h0;
      @(negedge iCLK);
      bus.iStart = 1'b0;
      #2;
      n_total++;
      if (bus.oDivZero !== 1'b1 || bus.oBusy !== 1'b0)
        $display("FAIL divzero_pulse: got divzero=%b busy=%b want 1 0", bus.oDivZero, bus.oBusy);
      else n_pass++;
      @(negedge iCLK);
      #2;
      n_total++;
      if (bus.oDivZero !== 1'b0 || bus.oBusy !== 1'b0 || bus.oDone !== 1'b0)
        $display("FAIL divzero_after: got divzero=%b busy=%b done=%b want 0 0 0",
                 bus.oDivZero, bus.oBusy, bus.oDone);
      else n_pass++;
      n_total++;
      if (bus.oHI !== 32'h11 || bus.oLO !== 32'h22)
        $display("FAIL divzero_hilo: got %h_%h want 11_22", bus.oHI, bus.oLO);
      else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b;
    int busy_n;
    a = $urandom;
    b = 32'($urandom_range(1, 1000));
    @(negedge iCLK);
    bus.iStart = 1'b1; bus.iOp = 3'd2; bus.iA = a; bus.iB = b;
    @(negedge iCLK);
    bus.iStart = 1'b0;
    busy_n = 1;
    repeat (9) begin
      @(negedge iCLK);
      busy_n++;
    end
    // Cycle 10 of the busy window: present a competing MULT 2x3.
    bus.iStart = 1'b1; bus.iOp = 3'd0; bus.iA = 32'd2; bus.iB = 32'd3;
    #2;
    n_total++;
    if (bus.oStall !== 1'b1) $display("FAIL busy_start_stall: got %b want 1", bus.oStall);
    else n_pass++;
    @(negedge iCLK);
    bus.iStart = 1'b0;
    #2;
    while (bus.oBusy && busy_n < 100) begin
      busy_n++;
      @(negedge iCLK);
      #2;
    end
    model_apply(3'd2, a, b);
    n_total++;
    if (busy_n !== 33) $display("FAIL busy_ignore_len: got %0d want 33", busy_n);
    else n_pass++;
    n_total++;
    if (bus.oDone !== 1'b1 || bus.oHI !== ref_hi || bus.oLO !== ref_lo)
      $display("FAIL busy_ignore_result: got done=%b %h_%h want 1 %h_%h",
               bus.oDone, bus.oHI, bus.oLO, ref_hi, ref_lo);
    else n_pass++;
    run_and_check("mult_reissue", 3'd0, 32'd2, 32'd3);
    n_total++;
    if (bus.oHI !== 32'h0 || bus.oLO !== 32'd6)
      $display("FAIL reissue_2x3: got %h_%h want 0_6", bus.oHI, bus.oLO);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit saw;
    @(negedge iCLK);
    bus.iStart = 1'b1; bus.iOp = 3'd0; bus.iA = $urandom; bus.iB = $urandom;
    @(negedge iCLK);
    bus.iStart = 1'b0;
    repeat (14) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    #2;
    ref_hi = '0;
    ref_lo = '0;
    n_total++;
    if (bus.oBusy !== 1'b0 || bus.oHI !== 32'h0 || bus.oLO !== 32'h0)
      $display("FAIL mid_reset_state: got busy=%b %h_%h want 0 0_0",
               bus.oBusy, bus.oHI, bus.oLO);
    else n_pass++;
    saw = 1'b0;
    repeat (40) begin
      if (bus.oDone || bus.oBusy) saw = 1'b1;
      @(negedge iCLK);
      #2;
    end
    n_total++;
    if (saw !== 1'b0) $display("FAIL mid_reset_quiet: got activity=%b want 0", saw);
    else n_pass++;
    do_mt(3'd5, 32'h1234);
    n_total++;
    if (bus.oLO !== 32'h1234 || bus.oDone !== 1'b0)
      $display("FAIL mtlo_after_reset: got lo=%h done=%b want 1234 0", bus.oLO, bus.oDone);
    else n_pass++;
  endtask

  task automatic test_reserved();
    for (int k = 6; k <= 7; k++) begin
      @(negedge iCLK);
      bus.iStart = 1'b1; bus.iOp = 3'(k); bus.iA = $urandom; bus.iB = $urandom;
      #2;
      n_total++;
      if (bus.oStall !== 1'b0) $display("FAIL reserved_stall: got %b want 0", bus.oStall);
      else n_pass++;
      @(negedge iCLK);
      bus.iStart = 1'b0;
      #2;
      n_total++;
      if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oHI !== ref_hi || bus.oLO !== ref_lo)
        $display("FAIL reserved_effect: got busy=%b done=%b %h_%h want 0 0 %h_%h",
                 bus.oBusy, bus.oDone, bus.oHI, bus.oLO, ref_hi, ref_lo);
      else n_pass++;
    end
  endtask

  task automatic test_read_and_start();
    logic [31:0] a, b;
    int busy_n;
    a = $urandom;
    b = $urandom;
    @(negedge iCLK);
    bus.iStart = 1'b1; bus.iRead = 1'b1; bus.iOp = 3'd1; bus.iA = a; bus.iB = b;
    #2;
    n_total++;
    if (bus.oStall !== 1'b0 || bus.oHI !== ref_hi || bus.oLO !== ref_lo)
      $display("FAIL read_start_idle: got stall=%b %h_%h want 0 %h_%h",
               bus.oStall, bus.oHI, bus.oLO, ref_hi, ref_lo);
    else n_pass++;
    @(negedge iCLK);
    bus.iStart = 1'b0; bus.iRead = 1'b0;
    #2;
    n_total++;
    if (bus.oBusy !== 1'b1) $display("FAIL read_start_accept: got busy=%b want 1", bus.oBusy);
    else n_pass++;
    busy_n = 0;
    while (bus.oBusy && busy_n < 100) begin
      busy_n++;
      @(negedge iCLK);
      #2;
    end
    model_apply(3'd1, a, b);
    n_total++;
    if (busy_n !== 33 || bus.oHI !== ref_hi || bus.oLO !== ref_lo)
      $display("FAIL read_start_result: got len=%0d %h_%h want 33 %h_%h",
               busy_n, bus.oHI, bus.oLO, ref_hi, ref_lo);
    else n_pass++;
  endtask

  initial begin
    iRST = 1'b1;
    bus.iStart = 1'b0;
    bus.iOp = 3'd0;
    bus.iA = '0;
    bus.iB = '0;
    bus.iRead = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_busy_ignore();
    test_mid_reset();
    test_reserved();
    test_read_and_start();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
